// File: rtl/parser_rule_cfg_ctrl_pkg.sv
// rtl/parser_rule_cfg_ctrl_pkg.sv - shared types and constants for the rule configuration controller
package parser_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } cfg_state_e;

    localparam int LAYER_SEL_MSB = 31;
    localparam int LAYER_SEL_LSB = 28;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  owner;
    } cfg_req_t;

endpackage

// File: rtl/parser_rule_cfg_ctrl_if.sv
// rtl/parser_rule_cfg_ctrl_if.sv - requester-side and layer-side buses of the rule configuration controller
interface cfg_req_if #(parameter int REQ_NUM = 2);
    logic [REQ_NUM-1:0]       req_valid;
    logic [REQ_NUM-1:0]       req_wr;
    logic [REQ_NUM-1:0][31:0] req_addr;
    logic [REQ_NUM-1:0][31:0] req_wdata;
    logic [REQ_NUM-1:0]       req_ready;
    logic [REQ_NUM-1:0]       rsp_valid;
    logic [31:0]              rsp_rdata;
    logic                     rsp_err;

    modport master (output req_valid, req_wr, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_wr, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface rule_bus_if #(parameter int LAYER_NUM = 4);
    logic [LAYER_NUM-1:0]       rule_wren;
    logic [LAYER_NUM-1:0]       rule_rden;
    logic [31:0]                rule_addr;
    logic [31:0]                rule_wdata;
    logic [LAYER_NUM-1:0]       rule_rdata_valid;
    logic [LAYER_NUM-1:0][31:0] rule_rdata;

    modport master (output rule_wren, rule_rden, rule_addr, rule_wdata,
                    input  rule_rdata_valid, rule_rdata);
    modport slave  (input  rule_wren, rule_rden, rule_addr, rule_wdata,
                    output rule_rdata_valid, rule_rdata);
endinterface

// File: rtl/parser_rule_cfg_ctrl_rr_arbiter.sv
// rtl/parser_rule_cfg_ctrl_rr_arbiter.sv - round-robin arbiter holding the last granted requester
module rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [REQ_NUM-1:0] i_req,
    input  logic               i_update,
    output logic [REQ_NUM-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);
    logic [IDX_W-1:0] last_grant_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int   cand;
        logic found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            cand = (int'(last_grant_q) + i) % REQ_NUM;
            if (!found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q <= IDX_W'(REQ_NUM - 1);
        end else if (i_update) begin
            last_grant_q <= o_idx;
        end
    end
endmodule

// File: rtl/parser_rule_cfg_ctrl.sv
// rtl/parser_rule_cfg_ctrl.sv - arbitrates rule read/write requests and drives one parser layer per transaction
module parser_rule_cfg_ctrl
    import parser_cfg_pkg::*;
#(
    parameter int LAYER_NUM = 4,
    parameter int REQ_NUM   = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    cfg_req_if.slave   req_if,
    rule_bus_if.master rule_if
);
    localparam int          IDX_W   = $clog2(REQ_NUM);
    localparam logic [4:0]  LAYER_W = 5'(LAYER_NUM);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    cfg_state_e           state_q;
    cfg_req_t             req_q;
    logic [7:0]           cnt_q;
    logic [LAYER_NUM-1:0] wren_q, rden_q;
    logic [REQ_NUM-1:0]   rsp_valid_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_err_q;

    logic [REQ_NUM-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 accept;
    cfg_req_t             in_req;
    logic [LAYER_NUM-1:0] in_oh;
    logic [3:0]           sel_layer;
    logic                 sel_ok, sel_vld;
    logic [31:0]          sel_rdata;
    logic [REQ_NUM-1:0]   owner_oh;

    rr_arbiter #(.REQ_NUM(REQ_NUM), .IDX_W(IDX_W)) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (req_if.req_valid),
        .i_update (accept),
        .o_grant  (grant),
        .o_idx    (grant_idx)
    );

    assign req_if.req_ready = (state_q == IDLE) ? grant : '0;
    assign accept           = (state_q == IDLE) && (|grant);

    assign in_req.wr    = req_if.req_wr[grant_idx];
    assign in_req.addr  = req_if.req_addr[grant_idx];
    assign in_req.wdata = req_if.req_wdata[grant_idx];
    assign in_req.owner = 8'(grant_idx);

    assign sel_layer = req_q.addr[LAYER_SEL_MSB:LAYER_SEL_LSB];
    assign sel_ok    = {1'b0, sel_layer} < LAYER_W;

    // Out-of-range layers decode to an empty one-hot, so no strobe is ever issued for them.
    always_comb begin
        in_oh     = '0;
        sel_vld   = 1'b0;
        sel_rdata = '0;
        owner_oh  = '0;
        for (int l = 0; l < LAYER_NUM; l++) begin
            if (in_req.addr[LAYER_SEL_MSB:LAYER_SEL_LSB] == 4'(l)) in_oh[l] = 1'b1;
            if (sel_layer == 4'(l)) begin
                sel_vld   = rule_if.rule_rdata_valid[l];
                sel_rdata = rule_if.rule_rdata[l];
            end
        end
        for (int r = 0; r < REQ_NUM; r++) begin
            if (req_q.owner == 8'(r)) owner_oh[r] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            wren_q      <= '0;
            rden_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            wren_q      <= '0;
            rden_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q <= in_req;
                        if (in_req.wr) wren_q <= in_oh;
                        else           rden_q <= in_oh;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (!sel_ok || req_q.wr || sel_vld) begin
                        rsp_valid_q <= owner_oh;
                        rsp_err_q   <= !sel_ok;
                        rsp_rdata_q <= (sel_ok && !req_q.wr) ? sel_rdata : '0;
                        state_q     <= RESP;
                    end else begin
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (sel_vld) begin
                        rsp_valid_q <= owner_oh;
                        rsp_rdata_q <= sel_rdata;
                        state_q     <= RESP;
                    end else if (cnt_q == TO_LAST) begin
                        rsp_valid_q <= owner_oh;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rule_if.rule_wren  = wren_q;
    assign rule_if.rule_rden  = rden_q;
    assign rule_if.rule_addr  = {4'b0, req_q.addr[27:0]};
    assign rule_if.rule_wdata = req_q.wdata;
    assign req_if.rsp_valid   = rsp_valid_q;
    assign req_if.rsp_rdata   = rsp_rdata_q;
    assign req_if.rsp_err     = rsp_err_q;
endmodule
